// File: rtl/iterative_mul_x_unit_pkg.sv
// Shared types and widths for the iterative multiply execute pipe.
// Holds the ISA micro-op encoding plus the register/metadata field widths.
package iterative_mul_x_unit_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned REG_ADDR_W    = 5;
    localparam int unsigned PREG_W        = 6;
    localparam int unsigned SEQ_NUM_W_DEF = 8;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_MUL  = 4'd5
    } rv_uop;

endpackage

// File: rtl/iterative_mul_x_unit_mul_step.sv
// One combinational shift-add step of the multiplier.
// Retires p_bits_per_cycle multiplier bits; all results wrap at 32 bits.
module iterative_mul_x_unit_mul_step
    import iterative_mul_x_unit_pkg::*;
#(
    parameter int unsigned p_bits_per_cycle = 1
) (
    input  logic [XLEN-1:0] acc_i,
    input  logic [XLEN-1:0] mcand_i,
    input  logic [XLEN-1:0] mplier_i,
    output logic [XLEN-1:0] acc_o,
    output logic [XLEN-1:0] mcand_o,
    output logic [XLEN-1:0] mplier_o
);

    always_comb begin
        acc_o = acc_i;
        for (int i = 0; i < int'(p_bits_per_cycle); i++) begin
            if (mplier_i[i]) begin
                acc_o = acc_o + (mcand_i << i);
            end
        end
        mcand_o  = mcand_i << p_bits_per_cycle;
        mplier_o = mplier_i >> p_bits_per_cycle;
    end

endmodule

// File: rtl/iterative_mul_x_unit.sv
// Iterative shift-add RV32M mul execute pipe with early termination.
// One op in flight; results held in DONE until writeback accepts them.
module iterative_mul_x_unit
    import iterative_mul_x_unit_pkg::*;
#(
    parameter int unsigned p_bits_per_cycle = 1,
    parameter int unsigned p_seq_num_bits   = SEQ_NUM_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      d_val_i,
    input  logic [XLEN-1:0]           d_pc_i,
    input  logic [XLEN-1:0]           d_op1_i,
    input  logic [XLEN-1:0]           d_op2_i,
    input  rv_uop                     d_uop_i,
    input  logic [REG_ADDR_W-1:0]     d_waddr_i,
    input  logic [p_seq_num_bits-1:0] d_seq_num_i,
    input  logic [PREG_W-1:0]         d_preg_i,
    input  logic [PREG_W-1:0]         d_ppreg_i,
    output logic                      d_rdy_o,
    output logic                      w_val_o,
    output logic [XLEN-1:0]           w_pc_o,
    output logic [p_seq_num_bits-1:0] w_seq_num_o,
    output logic [REG_ADDR_W-1:0]     w_waddr_o,
    output logic [XLEN-1:0]           w_wdata_o,
    output logic                      w_wen_o,
    output logic [PREG_W-1:0]         w_preg_o,
    output logic [PREG_W-1:0]         w_ppreg_o,
    input  logic                      w_rdy_i
);

    localparam int unsigned N     = XLEN / p_bits_per_cycle;
    localparam int unsigned CNT_W = $clog2(N) + 1;
    localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                      state_q;
    logic [XLEN-1:0]             acc_q, mcand_q, mplier_q;
    logic [XLEN-1:0]             acc_d, mcand_d, mplier_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [XLEN-1:0]             pc_q;
    logic [REG_ADDR_W-1:0]       waddr_q;
    logic [p_seq_num_bits-1:0]   seq_num_q;
    logic [PREG_W-1:0]           preg_q, ppreg_q;
    logic                        accept;

    // Every uop is executed as mul, so the opcode is never inspected.
    iterative_mul_x_unit_mul_step #(
        .p_bits_per_cycle (p_bits_per_cycle)
    ) u_step (
        .acc_i    (acc_q),
        .mcand_i  (mcand_q),
        .mplier_i (mplier_q),
        .acc_o    (acc_d),
        .mcand_o  (mcand_d),
        .mplier_o (mplier_d)
    );

    assign cnt_d  = cnt_q + 1'b1;
    assign accept = d_val_i & d_rdy_o;

    // DONE forwards writeback readiness so a new op can enter without a bubble.
    assign d_rdy_o = rst & ((state_q == IDLE) | ((state_q == DONE) & w_rdy_i));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            pc_q      <= '0;
            waddr_q   <= '0;
            seq_num_q <= '0;
            preg_q    <= '0;
            ppreg_q   <= '0;
        end else if (accept) begin
            state_q   <= CALC;
            acc_q     <= '0;
            mcand_q   <= d_op1_i;
            mplier_q  <= d_op2_i;
            cnt_q     <= '0;
            pc_q      <= d_pc_i;
            waddr_q   <= d_waddr_i;
            seq_num_q <= d_seq_num_i;
            preg_q    <= d_preg_i;
            ppreg_q   <= d_ppreg_i;
        end else begin
            case (state_q)
                CALC: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_d;
                    mplier_q <= mplier_d;
                    cnt_q    <= cnt_d;
                    if ((mplier_d == '0) || (cnt_d == N_CNT)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (w_rdy_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign w_val_o     = (state_q == DONE);
    assign w_wdata_o   = acc_q;
    assign w_wen_o     = (waddr_q != '0);
    assign w_pc_o      = pc_q;
    assign w_seq_num_o = seq_num_q;
    assign w_waddr_o   = waddr_q;
    assign w_preg_o    = preg_q;
    assign w_ppreg_o   = ppreg_q;

endmodule

// File: tb/tb_iterative_mul_x_unit.sv
// Directed-vector bench for iterative_mul_x_unit (1-bit and 4-bit step variants)
// plus a reference-model stream on the 4-bit variant.
module tb_iterative_mul_x_unit;
   import iterative_mul_x_unit_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;

   // Single-bit-per-cycle instance signals
   logic        dVal = 1'b0, dRdy, wVal, wWen, wRdy = 1'b1;
   logic [31:0] dPc = '0, dOp1 = '0, dOp2 = '0, wPc, wData;
   logic [4:0]  dWaddr = '0, wWaddr;
   logic [7:0]  dSeq = '0, wSeq;
   logic [5:0]  dPreg = '0, dPpreg = '0, wPreg, wPpreg;

   // Four-bits-per-cycle instance signals
   logic        dVal4 = 1'b0, dRdy4, wVal4, wWen4, wRdy4 = 1'b1;
   logic [31:0] dOp1x4 = '0, dOp2x4 = '0, wPc4, wData4;
   logic [4:0]  wWaddr4;
   logic [7:0]  dSeq4 = '0, wSeq4;
   logic [5:0]  wPreg4, wPpreg4;

   int compared = 0;
   int mismatched = 0;

   typedef struct {
      logic [31:0] op1;
      logic [31:0] op2;
      logic [4:0]  waddr;
      logic [7:0]  seq;
      logic [31:0] expData;
      int          expLat;
      logic        expWen;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic [7:0]  seq;
   } exp_t;

   vec_t vecs[9];
   exp_t expQ[$];

   always #5 clk = ~clk;

   iterative_mul_x_unit #(.p_bits_per_cycle(1), .p_seq_num_bits(8)) dut1 (
      .clk(clk), .rst(rst),
      .d_val_i(dVal), .d_pc_i(dPc), .d_op1_i(dOp1), .d_op2_i(dOp2), .d_uop_i(OP_MUL),
      .d_waddr_i(dWaddr), .d_seq_num_i(dSeq), .d_preg_i(dPreg), .d_ppreg_i(dPpreg),
      .d_rdy_o(dRdy),
      .w_val_o(wVal), .w_pc_o(wPc), .w_seq_num_o(wSeq), .w_waddr_o(wWaddr),
      .w_wdata_o(wData), .w_wen_o(wWen), .w_preg_o(wPreg), .w_ppreg_o(wPpreg),
      .w_rdy_i(wRdy)
   );

   iterative_mul_x_unit #(.p_bits_per_cycle(4), .p_seq_num_bits(8)) dut4 (
      .clk(clk), .rst(rst),
      .d_val_i(dVal4), .d_pc_i(32'h0), .d_op1_i(dOp1x4), .d_op2_i(dOp2x4), .d_uop_i(OP_MUL),
      .d_waddr_i(5'd1), .d_seq_num_i(dSeq4), .d_preg_i(6'd0), .d_ppreg_i(6'd0),
      .d_rdy_o(dRdy4),
      .w_val_o(wVal4), .w_pc_o(wPc4), .w_seq_num_o(wSeq4), .w_waddr_o(wWaddr4),
      .w_wdata_o(wData4), .w_wen_o(wWen4), .w_preg_o(wPreg4), .w_ppreg_o(wPpreg4),
      .w_rdy_i(wRdy4)
   );

   // Single comparison point: counts and reports every check
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Presents one op to dut1 and returns one tick after the accepting edge
   task automatic applyStimulus(input logic [31:0] op1, input logic [31:0] op2,
                                input logic [4:0] waddr, input logic [7:0] seq,
                                output int tries);
      tries = 0;
      dVal = 1'b1; dOp1 = op1; dOp2 = op2; dWaddr = waddr; dSeq = seq;
      dPc = 32'h1000 + {24'h0, seq}; dPreg = seq[5:0]; dPpreg = ~seq[5:0];
      #1;
      while (!dRdy && tries < 50) begin
         @(posedge clk); #1;
         tries++;
      end
      if (!dRdy) checkOutput("issueTimeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      dVal = 1'b0;
   endtask

   // Counts edges from the accepting edge until W.val is visible
   task automatic waitDone(output int lat);
      lat = 0;
      while (!wVal && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   // Stream driver for dut4: back-to-back issues with random multipliers
   task automatic driveStream4(input int count);
      exp_t e;
      int tries;
      for (int i = 0; i < count; i++) begin
         dVal4 = 1'b1;
         dOp1x4 = $urandom;
         dOp2x4 = $urandom >> $urandom_range(0, 31);
         dSeq4 = i[7:0];
         tries = 0;
         @(negedge clk);
         while (!dRdy4 && tries < 100) begin
            @(negedge clk);
            tries++;
         end
         e.data = dOp1x4 * dOp2x4;
         e.seq = dSeq4;
         expQ.push_back(e);
         @(posedge clk); #1;
      end
      dVal4 = 1'b0;
   endtask

   // Stream monitor for dut4: random backpressure, in-order scoreboard
   task automatic monitorStream4(input int count);
      exp_t e;
      int got = 0;
      int cyc = 0;
      while (got < count && cyc < 60000) begin
         @(posedge clk); #1;
         wRdy4 = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (wVal4 && wRdy4) begin
            if (expQ.size() == 0) begin
               checkOutput("streamUnexpected", 32'd1, 32'd0);
            end else begin
               e = expQ.pop_front();
               checkOutput("streamData", wData4, e.data);
               checkOutput("streamSeq", {24'h0, wSeq4}, {24'h0, e.seq});
            end
            got++;
         end
         cyc++;
      end
      checkOutput("streamCount", got, count);
      wRdy4 = 1'b1;
   endtask

   initial begin
      int lat;
      int tries;
      int seen;

      vecs[0] = '{32'd3,         32'd5,         5'd7,  8'd2,  32'd15,        3,  1'b1};
      vecs[1] = '{32'd9,         32'd0,         5'd4,  8'd1,  32'd0,         1,  1'b1};
      vecs[2] = '{32'd7,         32'hFFFFFFFF,  5'd3,  8'd3,  32'hFFFFFFF9,  32, 1'b1};
      vecs[3] = '{32'd5,         32'd6,         5'd0,  8'd4,  32'd30,        3,  1'b0};
      vecs[4] = '{32'h80000000,  32'd2,         5'd1,  8'd5,  32'd0,         2,  1'b1};
      vecs[5] = '{32'h00010000,  32'h00010000,  5'd2,  8'd6,  32'd0,         17, 1'b1};
      vecs[6] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  5'd31, 8'd7,  32'd1,         32, 1'b1};
      vecs[7] = '{32'd123,       32'd1,         5'd9,  8'd8,  32'd123,       1,  1'b1};
      vecs[8] = '{32'h00001234,  32'h00000080,  5'd0,  8'd9,  32'h00091A00,  8,  1'b0};

      // Reset state
      #2;
      checkOutput("resetWVal", {31'd0, wVal}, 32'd0);
      checkOutput("resetDRdy", {31'd0, dRdy}, 32'd0);
      repeat (2) @(posedge clk);
      #1; rst = 1'b1; #1;
      checkOutput("releaseDRdy", {31'd0, dRdy}, 32'd1);

      // Reset asserted in the fifth CALC cycle discards the op
      applyStimulus(32'd3, 32'hFFFFFFFF, 5'd5, 8'd99, tries);
      repeat (4) @(posedge clk);
      #1; rst = 1'b0; #1;
      checkOutput("midResetWVal", {31'd0, wVal}, 32'd0);
      checkOutput("midResetDRdy", {31'd0, dRdy}, 32'd0);
      @(posedge clk); #1;
      checkOutput("midResetHoldWVal", {31'd0, wVal}, 32'd0);
      rst = 1'b1; #1;
      checkOutput("postResetDRdy", {31'd0, dRdy}, 32'd1);
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (wVal) seen++;
      end
      checkOutput("postResetNoWVal", seen, 32'd0);

      // Directed vector table
      wRdy = 1'b1;
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].op1, vecs[i].op2, vecs[i].waddr, vecs[i].seq, tries);
         waitDone(lat);
         checkOutput($sformatf("v%0d_lat", i), lat, vecs[i].expLat);
         checkOutput($sformatf("v%0d_wdata", i), wData, vecs[i].expData);
         checkOutput($sformatf("v%0d_wen", i), {31'd0, wWen}, {31'd0, vecs[i].expWen});
         checkOutput($sformatf("v%0d_waddr", i), {27'd0, wWaddr}, {27'd0, vecs[i].waddr});
         checkOutput($sformatf("v%0d_seq", i), {24'd0, wSeq}, {24'd0, vecs[i].seq});
         checkOutput($sformatf("v%0d_pc", i), wPc, 32'h1000 + {24'h0, vecs[i].seq});
         checkOutput($sformatf("v%0d_preg", i), {26'd0, wPreg}, {26'd0, vecs[i].seq[5:0]});
         @(posedge clk); #1;
      end

      // Writeback backpressure, then back-to-back handoff
      wRdy = 1'b0;
      applyStimulus(32'd3, 32'd5, 5'd9, 8'd20, tries);
      waitDone(lat);
      checkOutput("bpLat", lat, 32'd3);
      for (int c = 0; c < 4; c++) begin
         checkOutput($sformatf("bpWVal%0d", c), {31'd0, wVal}, 32'd1);
         checkOutput($sformatf("bpWData%0d", c), wData, 32'd15);
         checkOutput($sformatf("bpSeq%0d", c), {24'd0, wSeq}, 32'd20);
         checkOutput($sformatf("bpWaddr%0d", c), {27'd0, wWaddr}, 32'd9);
         checkOutput($sformatf("bpDRdy%0d", c), {31'd0, dRdy}, 32'd0);
         @(posedge clk); #1;
      end
      wRdy = 1'b1;
      applyStimulus(32'd4, 32'd3, 5'd10, 8'd21, tries);
      checkOutput("b2bImmediateAccept", tries, 32'd0);
      waitDone(lat);
      checkOutput("b2bLat", lat, 32'd2);
      checkOutput("b2bWData", wData, 32'd12);
      checkOutput("b2bSeq", {24'd0, wSeq}, 32'd21);
      @(posedge clk); #1;

      // Four-bit step: all-ones multiplier takes the full eight steps
      dVal4 = 1'b1; dOp1x4 = 32'h12345678; dOp2x4 = 32'hFFFFFFFF; dSeq4 = 8'd200;
      #1;
      checkOutput("w4DRdy", {31'd0, dRdy4}, 32'd1);
      @(posedge clk); #1;
      dVal4 = 1'b0;
      lat = 0;
      while (!wVal4 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      checkOutput("w4Lat", lat, 32'd8);
      checkOutput("w4WData", wData4, 32'hEDCBA988);
      @(posedge clk); #1;

      fork
         driveStream4(1000);
         monitorStream4(1000);
      join

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/iterative_mul_x_unit.md
# iterative_mul_x_unit

Execute-stage pipe that computes the RV32M `mul` result (low 32 bits of op1 × op2) with an iterative shift-add datapath. It sits directly downstream of the decode/issue unit as one entry of its execute-pipe array. It consumes one issued micro-op through the D→X interface and delivers one result per operation to writeback through the X→W interface. Latency is variable, with early termination when the remaining multiplier bits are zero.

## Interface
- `p_bits_per_cycle`, default 1: multiplier bits retired per CALC cycle; legal values 1, 2, 4. `N = 32 / p_bits_per_cycle`.
- `p_seq_num_bits`, default taken from `D.p_seq_num_bits`: sequence-number width; must equal `W.p_seq_num_bits`.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `D`, `D__XIntf.X_intf`: issue side. Inputs are `val`, `pc`, `op1`, `op2`, `uop`, `waddr`, `seq_num`, `preg`, `ppreg`. Output is `rdy`.
- `W`, `X__WIntf.X_intf`: writeback side. Outputs are `val`, `pc`, `seq_num`, `waddr`, `wdata`, `wen`, `preg`, `ppreg`. Input is `rdy`.

## Operation
- The FSM has three states: IDLE, CALC and DONE.
- **IDLE**
  - `D.rdy = 1`.
  - On `D.val & D.rdy`, capture `acc = 0`, `mcand = op1`, `mplier = op2`, `cnt = 0` and the metadata (`pc`, `waddr`, `seq_num`, `preg`, `ppreg`).
  - Then go to CALC.
- **CALC**, one step per cycle, with `k = p_bits_per_cycle`:
  - `acc += mcand * mplier[k-1:0]`, truncated to 32 bits.
  - `mcand <<= k`, `mplier >>= k` (logical), `cnt += 1`.
  - Go to DONE when the post-update `mplier == 0` or `cnt == N`. Otherwise stay in CALC.
- **DONE**
  - `W.val = 1`, `W.wdata = acc`.
  - `W.wen = (waddr != 0)`.
  - Metadata is driven from the captured registers.
  - On `W.rdy`: go to IDLE.
    - Exception: if `D.val` is also high, capture the new op and go straight to CALC (back-to-back, no bubble).
  - `D.rdy = W.rdy` in DONE.
- **Uop support**
  - Only `OP_MUL` is legal; the router guarantees it.
  - Any other uop is still computed as `mul` and carries no error signalling.
- **Signedness:** signed and unsigned multiply give the same low 32 bits, so no sign handling is needed.
- **Truncation:** partial products and `mcand` shifts are truncated to 32 bits; overflow wraps silently.
- **Interface rules:** `D.rdy = 0` in CALC. `W.val` is asserted only in DONE.

## Timing
- **Reset (`rst = 0`):**
  - State goes to IDLE immediately.
  - `W.val = 0`, `D.rdy = 0` while `rst` is low. `D.rdy` is gated by `rst`.
  - Datapath registers are don't-care.
- **Reset mid-operation:** the in-flight op is discarded and no W transfer occurs.
- **First cycle after release:** `D.rdy = 1`.
- **Latency:**
  - D transfer in cycle c.
  - CALC occupies cycles c+1 … c+j, with 1 ≤ j ≤ N.
  - `W.val` rises in cycle c+j+1.
  - `j = max(1, ceil(bitlen(op2)/k))`; `op2 = 0` gives j = 1.
- **W stall:** `W.val` and all W outputs hold stable until `W.rdy`.
- **Simultaneous W transfer and D transfer in DONE:** the new op's CALC starts in the next cycle.
- **Throughput:** one op per j+1 cycles.
- **Counter:** `cnt` is `$clog2(N)+1` bits wide and never wraps.

## Structure
- `OP_MUL` and `rv_uop` come from the shared `ISA` package.
- The state enum (`IDLE`, `CALC`, `DONE`) is local to the module and not shared.
- Sub-module `mul_step` is purely combinational. It takes `acc`, `mcand` and `mplier` and returns their next values for one CALC cycle, parameterised by `p_bits_per_cycle`.
- The top level holds the FSM, counter, metadata registers and handshake logic.

## Test plan
All scenarios use `p_bits_per_cycle = 1` unless noted.
1. **Reset mid-CALC:** issue op `op1=3, op2=0xFFFFFFFF`; pull `rst` low in the 5th CALC cycle, then release. Required response: `W.val` never rises, and `D.rdy = 1` in the first cycle after release.
2. **Basic transfer:** issue `op1=3, op2=5, waddr=7, seq_num=2` in cycle 0 with `W.rdy = 1`. Required response:
   - CALC in cycles 1–3.
   - In cycle 4: `W.val = 1`, `wdata = 15`, `waddr = 7`, `wen = 1`, `seq_num = 2`.
3. **Early termination and x0:**
   - `op2 = 0`, `op1 = 9`: `W.val` in cycle 2 with `wdata = 0`.
   - `op2 = 0xFFFFFFFF`, `op1 = 7`: `W.val` in cycle 33 with `wdata = 0xFFFFFFF9`.
   - `waddr = 0` on any op: `wen = 0`.
4. **Wrap:** `op1 = 0x80000000, op2 = 2` gives `wdata = 0`. `op1 = 0x10000, op2 = 0x10000` gives `wdata = 0`.
5. **W backpressure:** hold `W.rdy = 0` for 4 cycles in DONE. Required response:
   - `W` outputs stable throughout and `D.rdy = 0`.
   - When `W.rdy` rises with `D.val = 1`, the new op is accepted in the same cycle and its CALC starts in the next cycle.
6. **Wider step (`p_bits_per_cycle = 4`):** `op1 = 0x12345678, op2 = 0xFFFFFFFF` gives 8 CALC cycles and `wdata = 0xEDCBA988`. A 1000-op random stream is checked against a reference model, including results and ordering.
